// File: rtl/sram_prog_loader.sv
// sram_prog_loader
//
// Fetches a length-prefixed program image from an external asynchronous 16-bit
// SRAM and streams the body words to the instruction scheduler through a small
// first-word-fall-through FIFO. This block owns every SRAM control pin, so all
// SRAM read timing lives here.
//
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   start      in   one-cycle load request, honoured only when idle
//   base_addr  in   SRAM word address of the length header (sampled with start)
//   sram_dq    in   SRAM read data
//   sram_addr  out  SRAM word address
//   sram_ce_n  out  chip enable (active-low)
//   sram_oe_n  out  output enable (active-low)
//   sram_we_n  out  write enable (active-low), tied high: read-only master
//   sram_lb_n  out  lower byte enable (active-low)
//   sram_ub_n  out  upper byte enable (active-low)
//   ins_data   out  FIFO head word
//   ins_valid  out  ins_data holds a word
//   ins_ready  in   consumer takes the word when ins_valid && ins_ready
//   busy       out  load in progress (through the done cycle)
//   done       out  one-cycle pulse when the load finishes and the FIFO is drained
//   prog_len   out  latched header value
//   err        out  sticky: header exceeded MAX_LEN

module sram_prog_loader #(
    parameter int unsigned ACC_CYCLES = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned MAX_LEN    = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] base_addr,
    input  logic [15:0] sram_dq,
    output logic [19:0] sram_addr,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n,
    output logic [15:0] ins_data,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] prog_len,
    output logic        err
);

    localparam int unsigned CntW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
    localparam logic [CntW-1:0] CntInit = CntW'(ACC_CYCLES - 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned OccW = $clog2(FIFO_DEPTH + 1);
    localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);
    localparam logic [16:0] MaxLen = 17'(MAX_LEN);

    typedef enum logic [2:0] {
        StIdle,
        StHdrWait,
        StBodyIssue,
        StBodyWait,
        StFinish
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [19:0]       addr_q, addr_d;
    logic [15:0]       rem_q, rem_d;
    logic [15:0]       prog_len_q, prog_len_d;
    logic              err_q, err_d;
    logic              pins_on;
    logic              push;

    // FIFO state
    logic [15:0]       fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OccW-1:0]   occ_q;
    logic              pop;
    logic              do_push;

    // ------------------------------------------------------------------
    // Control FSM: next-state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        prog_len_d = prog_len_q;
        err_d      = err_q;
        pins_on    = 1'b0;
        push       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d  = base_addr;
                    err_d   = 1'b0;
                    cnt_d   = CntInit;
                    state_d = StHdrWait;
                end
            end
            StHdrWait: begin
                pins_on = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    prog_len_d = sram_dq;
                    rem_d      = sram_dq;
                    if ({1'b0, sram_dq} > MaxLen) begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end else if (sram_dq == 16'd0) begin
                        state_d = StFinish;
                    end else begin
                        addr_d  = addr_q + 20'd1;
                        state_d = StBodyIssue;
                    end
                end
            end
            StBodyIssue: begin
                // Single outstanding read: a free slot now is still free when
                // the word lands, since the consumer can only drain the FIFO.
                if (occ_q < OccFull) begin
                    cnt_d   = CntInit;
                    state_d = StBodyWait;
                end
            end
            StBodyWait: begin
                pins_on = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CntW'(1);
                end else begin
                    push   = 1'b1;
                    rem_d  = rem_q - 16'd1;
                    addr_d = addr_q + 20'd1;
                    state_d = (rem_q == 16'd1) ? StFinish : StBodyIssue;
                end
            end
            StFinish: begin
                if (occ_q == '0) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            rem_q      <= '0;
            prog_len_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            prog_len_q <= prog_len_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (first-word fall-through)
    // ------------------------------------------------------------------
    assign ins_valid = (occ_q != '0);
    assign ins_data  = fifo_mem[rd_ptr_q];
    assign pop       = ins_valid & ins_ready;
    // A push into a full FIFO is only taken if a pop frees the slot this cycle.
    assign do_push   = push & ((occ_q != OccFull) | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !pop) begin
                occ_q <= occ_q + OccW'(1);
            end else if (!do_push && pop) begin
                occ_q <= occ_q - OccW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= sram_dq;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sram_addr = addr_q;
    assign sram_ce_n = ~pins_on;
    assign sram_oe_n = ~pins_on;
    assign sram_lb_n = ~pins_on;
    assign sram_ub_n = ~pins_on;
    assign sram_we_n = 1'b1;
    assign busy      = (state_q != StIdle);
    assign prog_len  = prog_len_q;
    assign err       = err_q;

endmodule

// File: tb/tb_sram_prog_loader.sv
module tb_sram_prog_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [19:0] base_addr = '0;
    logic [15:0] sram_dq = '0;
    logic [19:0] sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;
    logic [15:0] ins_data;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic        busy, done, err;
    logic [15:0] prog_len;

    sram_prog_loader #(
        .ACC_CYCLES(2),
        .FIFO_DEPTH(4),
        .MAX_LEN   (1024)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .base_addr(base_addr),
        .sram_dq  (sram_dq),
        .sram_addr(sram_addr),
        .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n),
        .sram_lb_n(sram_lb_n),
        .sram_ub_n(sram_ub_n),
        .ins_data (ins_data),
        .ins_valid(ins_valid),
        .ins_ready(ins_ready),
        .busy     (busy),
        .done     (done),
        .prog_len (prog_len),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: data follows the address half a cycle later,
    // and reads as a poison value unless the chip is selected and enabled.
    logic [15:0] sram [logic [19:0]];
    always @(negedge clk) begin
        if (!sram_ce_n && !sram_oe_n && sram.exists(sram_addr))
            sram_dq <= sram[sram_addr];
        else
            sram_dq <= 16'hDEAD;
    end

    int          n_vec = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          oe_run = 0;
    logic        oe_prev = 1'b1;
    logic        we_low = 1'b0;
    logic [15:0] exp_q [$];
    logic [19:0] read_addrs [$];
    logic [15:0] exp_w;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
        end
    endtask

    task automatic load_img(input logic [19:0] base, input logic [15:0] hdr,
                            input int nwords, input logic [15:0] first);
        logic [19:0] a;
        sram[base] = hdr;
        for (int i = 0; i < nwords; i++) begin
            a = base + 20'(i + 1);
            sram[a] = first + 16'(i);
        end
    endtask

    task automatic expect_words(input logic [15:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 16'(i));
    endtask

    task automatic do_start(input logic [19:0] base);
        base_addr = base;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            tick();
            cycles++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    int c;
    int dc;
    int k;

    initial begin
        // Monitor: scoreboard pops and SRAM pin protocol observation.
        fork
            forever begin
                @(negedge clk);
                if (sram_we_n !== 1'b1) we_low = 1'b1;
                if (!reset) begin
                    oe_run  = 0;
                    oe_prev = 1'b1;
                end else begin
                    if (!sram_oe_n) begin
                        if (oe_prev) read_addrs.push_back(sram_addr);
                        oe_run++;
                    end else if (oe_run != 0) begin
                        n_vec++;
                        if (oe_run != 2) begin
                            n_err++;
                            $display("FAIL oe_width: got %0d cycles, want 2", oe_run);
                        end
                        oe_run = 0;
                    end
                    oe_prev = sram_oe_n;
                    if (done) done_cnt++;
                    if (ins_valid && ins_ready) begin
                        n_vec++;
                        if (exp_q.size() == 0) begin
                            n_err++;
                            $display("FAIL stream_word: got 0x%0h, want no word", ins_data);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (ins_data !== exp_w) begin
                                n_err++;
                                $display("FAIL stream_word: got 0x%0h, want 0x%0h",
                                         ins_data, exp_w);
                            end
                        end
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) tick();
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_pins", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n},
            32'h1F);
        chk("rst_flags", {28'd0, ins_valid, busy, done, err}, 32'h0);
        chk("rst_prog_len", 32'(prog_len), 32'h0);
        reset = 1'b1;
        tick();

        // T1: basic 3-word load
        load_img(20'h00100, 16'd3, 3, 16'h00A1);
        expect_words(16'h00A1, 3);
        read_addrs.delete();
        ins_ready = 1'b1;
        dc = done_cnt;
        do_start(20'h00100);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 200, c);
        tick();
        chk("t1_prog_len", 32'(prog_len), 32'd3);
        chk("t1_err", {31'd0, err}, 32'd0);
        chk("t1_busy_off", {31'd0, busy}, 32'd0);
        chk("t1_done_pulses", 32'(done_cnt - dc), 32'd1);
        chk("t1_drained", 32'(exp_q.size()), 32'd0);
        chk("t1_reads", 32'(read_addrs.size()), 32'd4);
        for (int i = 0; i < 4 && i < read_addrs.size(); i++)
            chk("t1_read_addr", 32'(read_addrs[i]), 32'h100 + 32'(i));

        // T2: back-pressure, FIFO fills and SRAM reads stop
        load_img(20'h00200, 16'd10, 10, 16'h00B0);
        expect_words(16'h00B0, 10);
        read_addrs.delete();
        ins_ready = 1'b0;
        dc = done_cnt;
        do_start(20'h00200);
        repeat (40) tick();
        chk("t2_reads_while_full", 32'(read_addrs.size()), 32'd5);
        chk("t2_valid", {31'd0, ins_valid}, 32'd1);
        chk("t2_head", 32'(ins_data), 32'h00B0);
        chk("t2_oe_idle", {31'd0, sram_oe_n}, 32'd1);
        ins_ready = 1'b1;
        wait_done("t2_done", 300, c);
        tick();
        chk("t2_drained", 32'(exp_q.size()), 32'd0);
        chk("t2_prog_len", 32'(prog_len), 32'd10);
        chk("t2_done_pulses", 32'(done_cnt - dc), 32'd1);

        // T3: empty program
        sram[20'h00300] = 16'd0;
        read_addrs.delete();
        do_start(20'h00300);
        wait_done("t3_done", 20, c);
        chk("t3_latency_ok", {31'd0, (c + 1) <= 4}, 32'd1);
        tick();
        chk("t3_busy_off", {31'd0, busy}, 32'd0);
        chk("t3_prog_len", 32'(prog_len), 32'd0);
        chk("t3_reads", 32'(read_addrs.size()), 32'd1);
        chk("t3_no_output", {31'd0, ins_valid}, 32'd0);

        // T4: oversize header then recovery
        sram[20'h00400] = 16'd2000;
        read_addrs.delete();
        do_start(20'h00400);
        wait_done("t4_done", 50, c);
        tick();
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_prog_len", 32'(prog_len), 32'd2000);
        chk("t4_no_body_reads", 32'(read_addrs.size()), 32'd1);
        chk("t4_busy_off", {31'd0, busy}, 32'd0);
        expect_words(16'h00A1, 3);
        do_start(20'h00100);
        chk("t4_err_cleared", {31'd0, err}, 32'd0);
        wait_done("t4_reload_done", 200, c);
        tick();
        chk("t4_reload_len", 32'(prog_len), 32'd3);
        chk("t4_reload_drained", 32'(exp_q.size()), 32'd0);

        // T5: address wrap at the top of the SRAM
        load_img(20'hFFFFE, 16'd3, 3, 16'h00C1);
        expect_words(16'h00C1, 3);
        read_addrs.delete();
        do_start(20'hFFFFE);
        wait_done("t5_done", 200, c);
        tick();
        chk("t5_reads", 32'(read_addrs.size()), 32'd4);
        if (read_addrs.size() == 4) begin
            chk("t5_addr0", 32'(read_addrs[1]), 32'hFFFFF);
            chk("t5_addr1", 32'(read_addrs[2]), 32'h00000);
            chk("t5_addr2", 32'(read_addrs[3]), 32'h00001);
        end
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // T6: reset mid-body read, then full reload with an ignored start
        expect_words(16'h00B0, 10);
        read_addrs.delete();
        do_start(20'h00200);
        k = 0;
        while (!(read_addrs.size() >= 3 && !sram_oe_n) && k < 100) begin
            tick();
            k++;
        end
        chk("t6_reached_body", {31'd0, k < 100}, 32'd1);
        reset = 1'b0;
        #1;
        chk("t6_rst_addr", 32'(sram_addr), 32'h0);
        chk("t6_rst_pins", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n},
            32'h1F);
        chk("t6_rst_flags", {28'd0, ins_valid, busy, done, err}, 32'h0);
        chk("t6_rst_prog_len", 32'(prog_len), 32'h0);
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
        tick();
        expect_words(16'h00B0, 10);
        read_addrs.delete();
        dc = done_cnt;
        do_start(20'h00200);
        repeat (3) tick();
        do_start(20'h00300);
        chk("t6_busy_held", {31'd0, busy}, 32'd1);
        wait_done("t6_done", 300, c);
        tick();
        chk("t6_prog_len", 32'(prog_len), 32'd10);
        chk("t6_drained", 32'(exp_q.size()), 32'd0);
        chk("t6_reads", 32'(read_addrs.size()), 32'd11);
        if (read_addrs.size() > 0) chk("t6_hdr_addr", 32'(read_addrs[0]), 32'h200);
        chk("t6_done_pulses", 32'(done_cnt - dc), 32'd1);

        chk("we_n_never_low", {31'd0, we_low}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_prog_loader.md
Name: sram_prog_loader

Overview:
- Upstream stage of the instruction scheduler: fetches a length-prefixed program image from the board's external asynchronous 16-bit SRAM.
- Buffers the fetched words in a small FIFO and presents them to the scheduler as a valid/ready word stream.
- Owns all SRAM control pins (CE/OE/WE/LB/UB) and the 20-bit SRAM address bus, so SRAM timing lives in one place and the scheduler no longer touches SRAM pins.

Parameters:
- ACC_CYCLES, 2, cycles from address/OE drive to `sram_dq` sample; must be >= 1.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2.
- MAX_LEN, 1024, largest accepted program length in words (header value).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load request; sampled only in IDLE.
- base_addr  in  20  SRAM word address of the length header; sampled with `start`.
- sram_dq  in  16  SRAM read data.
- sram_addr  out  20  SRAM word address.
- sram_ce_n  out  1  SRAM chip enable, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.
- sram_we_n  out  1  SRAM write enable, active-low; constant 1.
- sram_lb_n  out  1  SRAM lower byte enable, active-low.
- sram_ub_n  out  1  SRAM upper byte enable, active-low.
- ins_data  out  16  FIFO head word (first-word fall-through).
- ins_valid  out  1  `ins_data` is valid.
- ins_ready  in  1  consumer accepts the word when `ins_valid` and `ins_ready` are both high.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when the load completes.
- prog_len  out  16  latched header value.
- err  out  1  sticky; header exceeded `MAX_LEN`.

Behaviour:
- Reset (`reset`=0, async) forces:
  - `sram_addr`=0; `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` all 1.
  - `ins_valid`=0, `busy`=0, `done`=0, `err`=0, `prog_len`=0.
  - FIFO flushed; state IDLE.
- Reset mid-load aborts the load immediately; the partial stream is discarded.
- States:
  - IDLE:
    - `start`=1 → latch `base_addr`; `sram_addr`<=`base_addr`; clear `err`; `busy`<=1; go to HDR_WAIT with the wait counter loaded to ACC_CYCLES-1.
  - HDR_WAIT:
    - `ce_n`/`oe_n`/`lb_n`/`ub_n` = 0.
    - Counter decrements each cycle; at 0, sample `sram_dq` into `prog_len` and the remaining-word counter.
    - Header > `MAX_LEN` → `err`<=1, go to FINISH.
    - Header 0 → go to FINISH.
    - Otherwise `sram_addr`<=`sram_addr`+1 and go to BODY_ISSUE.
  - BODY_ISSUE:
    - Wait until FIFO occupancy < FIFO_DEPTH (only one read outstanding, so no over-commit).
    - Then load counter = ACC_CYCLES-1 and go to BODY_WAIT.
    - SRAM pins deasserted (all 1) while stalled.
  - BODY_WAIT:
    - Pins asserted as in HDR_WAIT.
    - At counter 0: push `sram_dq` into the FIFO; remaining -= 1; `sram_addr` += 1 (mod 2^20, wraps 0xFFFFF→0x00000).
    - remaining == 0 → FINISH; else → BODY_ISSUE.
  - FINISH:
    - SRAM pins deasserted.
    - Wait until the FIFO is empty (all words consumed), then `done`=1 for exactly one cycle, `busy`<=0, go to IDLE.
- Read latency: ACC_CYCLES cycles of asserted OE per word. Unstalled throughput is 1 word per (ACC_CYCLES+1) cycles.
- FIFO:
  - Push and pop in the same cycle is legal, including when full (occupancy unchanged) and when empty-with-push (no pop possible).
  - `ins_data` is stable while `ins_valid`=1 and `ins_ready`=0.
- `busy` is 1 from the cycle after `start` is accepted through the `done` cycle inclusive.
- `start` while not IDLE is ignored.
- The header word is never placed in the FIFO.
- `err` holds until the next accepted `start` or reset; no body reads occur when `err` is set.
- `sram_we_n` is never 0.

Test Plan:
- SRAM model [0x100]=3, [0x101..0x103]=0xA1,0xA2,0xA3; `start` with `base_addr`=0x100, `ins_ready`=1 → exactly 0xA1,0xA2,0xA3 accepted in order; `prog_len`=3; one `done` pulse; `sram_we_n`=1 throughout; each read holds OE low 2 cycles.
- Same image, 10 words, `ins_ready`=0 for 40 cycles → FIFO fills to 4, no SRAM read asserted while full; release `ins_ready` → all 10 words delivered, none lost or duplicated.
- Header=0 → no FIFO output; `done` pulses ≤ ACC_CYCLES+2 cycles after `start`; `busy` returns to 0.
- Header=2000 (> MAX_LEN) → `err`=1; no body reads; `done` pulses; next `start` with a valid image clears `err` and loads normally.
- `base_addr`=0xFFFFE, header=3 → body read addresses 0xFFFFF, 0x00000, 0x00001.
- Assert `reset` low mid-BODY_WAIT → outputs return to reset values asynchronously; a subsequent `start` reloads the full program correctly; a `start` pulsed while `busy` has no effect.
